exh_vec_bist: RTL and testbench



---
 rtl/exh_vec_bist.sv | 197 +++++++++++++++++++
 tb/tb_exh_vec_bist.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exh_vec_bist.sv
// exh_vec_bist
// Exhaustive-stimulus generator and response compactor for a small
// combinational block. Walks every input combination in ascending order,
// holds each one for HOLD_CYC cycles, samples the block output once per
// vector on the last held cycle, and folds the samples into a raw response
// word and a CRC signature compared against GOLDEN at the end of the run.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle run request (ignored while a run is active)
//   vec_out   out  stimulus to the block under test (MSB = input a)
//   dut_z     in   output of the block under test
//   busy      out  run in progress
//   done      out  run complete, sticky until the next start
//   pass      out  valid with done; 1 when signature matched GOLDEN
//   resp      out  raw responses, bit i = sample taken for vector i
//   signature out  compacted response
module exh_vec_bist #(
    parameter int              N_IN     = 3,
    parameter int              HOLD_CYC = 10,
    parameter int              SIG_W    = 16,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'hFFFF,
    parameter logic [SIG_W-1:0] GOLDEN  = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   dut_z,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   resp,
    output logic [SIG_W-1:0]       signature
);

    localparam int NV = 1 << N_IN;
    localparam logic [N_IN:0]   IDX_ONE  = 1;
    localparam logic [N_IN:0]   IDX_LAST = NV - 1;
    localparam logic [N_IN-1:0] VEC_ONE  = 1;
    localparam logic [7:0]      HOLD_ONE = 8'd1;
    localparam logic [7:0]      HOLD_END = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One CRC step: shift left, feed back POLY on a set MSB, then mix the
    // sampled response into the LSB.
    function automatic logic [SIG_W-1:0] crc_step(input logic [SIG_W-1:0] sig,
                                                  input logic             z);
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, z};
    endfunction

    state_t            state_r, state_s;
    logic [N_IN:0]     vec_idx_r, vec_idx_s;
    logic [7:0]        hold_cnt_r, hold_cnt_s;
    logic [N_IN-1:0]   vec_out_r, vec_out_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              pass_r, pass_s;
    logic [NV-1:0]     resp_r, resp_s;
    logic [SIG_W-1:0]  sig_r, sig_s;
    logic              sample_s;
    logic              last_s;
    logic [SIG_W-1:0]  sig_step_s;

    assign sample_s   = (state_r == ST_RUN) && (hold_cnt_r == HOLD_END);
    assign last_s     = (vec_idx_r == IDX_LAST);
    assign sig_step_s = crc_step(sig_r, dut_z);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; start is only honoured outside RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (sample_s && last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        vec_idx_s  = vec_idx_r;
        hold_cnt_s = hold_cnt_r;
        vec_out_s  = vec_out_r;
        busy_s     = busy_r;
        done_s     = done_r;
        pass_s     = pass_r;
        resp_s     = resp_r;
        sig_s      = sig_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_idx_s  = {(N_IN+1){1'b0}};
                    hold_cnt_s = 8'd0;
                    vec_out_s  = {N_IN{1'b0}};
                    busy_s     = 1'b1;
                    done_s     = 1'b0;
                    pass_s     = 1'b0;
                    resp_s     = {NV{1'b0}};
                    sig_s      = SEED;
                end else begin
                    busy_s = busy_r;
                end
            end
            ST_RUN: begin
                if (sample_s) begin
                    resp_s[vec_idx_r[N_IN-1:0]] = dut_z;
                    sig_s      = sig_step_s;
                    hold_cnt_s = 8'd0;
                    if (last_s) begin
                        // Pass is judged on the signature being written now.
                        busy_s    = 1'b0;
                        done_s    = 1'b1;
                        pass_s    = (sig_step_s == GOLDEN);
                        vec_out_s = {N_IN{1'b0}};
                        vec_idx_s = {(N_IN+1){1'b0}};
                    end else begin
                        vec_idx_s = vec_idx_r + IDX_ONE;
                        vec_out_s = vec_out_r + VEC_ONE;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            default: begin
                vec_idx_s  = {(N_IN+1){1'b0}};
                hold_cnt_s = 8'd0;
                vec_out_s  = {N_IN{1'b0}};
                busy_s     = 1'b0;
                done_s     = 1'b0;
                pass_s     = 1'b0;
                resp_s     = {NV{1'b0}};
                sig_s      = SEED;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx_r  <= {(N_IN+1){1'b0}};
            hold_cnt_r <= 8'd0;
            vec_out_r  <= {N_IN{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            resp_r     <= {NV{1'b0}};
            sig_r      <= SEED;
        end else begin
            vec_idx_r  <= vec_idx_s;
            hold_cnt_r <= hold_cnt_s;
            vec_out_r  <= vec_out_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            resp_r     <= resp_s;
            sig_r      <= sig_s;
        end
    end

    assign vec_out   = vec_out_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign resp      = resp_r;
    assign signature = sig_r;

endmodule

// File: tb/tb_exh_vec_bist.sv
// Bench for exh_vec_bist: a run-level behavioural model tracks elapsed
// cycles since start and derives every output from that; one compare process
// checks the design against it after every clock edge and reset assertion,
// and pins the model with literal results at each completed run.
module tb_exh_vec_bist;

    localparam int N_IN = 3;
    localparam int HOLD = 10;
    localparam int NV   = 8;
    localparam logic [15:0] POLY   = 16'h1021;
    localparam logic [15:0] SEED   = 16'hFFFF;
    localparam logic [15:0] GOLDEN = 16'hE199;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [N_IN-1:0] vec_out;
    logic            dut_z;
    logic            busy;
    logic            done;
    logic            pass;
    logic [NV-1:0]   resp;
    logic [15:0]     signature;

    logic mode;        // 1: dut_z = parity of vec_out, 0: dut_z forced low
    logic timed_out;
    int   total;
    int   bad;

    assign dut_z = mode ? ^vec_out : 1'b0;

    exh_vec_bist #(
        .N_IN(N_IN), .HOLD_CYC(HOLD), .SIG_W(16),
        .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out),
        .dut_z(dut_z), .busy(busy), .done(done), .pass(pass),
        .resp(resp), .signature(signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: a run is described by how many edges elapsed since start.
    bit          m_run;
    int          m_t;
    logic        m_done;
    logic        m_pass;
    logic [NV-1:0] m_resp;
    logic [15:0] m_sig;
    int          m_vec;

    function automatic logic [15:0] crc(input logic [15:0] s, input logic z);
        logic [15:0] r;
        r = s << 1;
        if (s[15]) r = r ^ POLY;
        r[0] = r[0] ^ z;
        return r;
    endfunction

    initial begin
        m_run = 0; m_t = 0; m_done = 0; m_pass = 0;
        m_resp = '0; m_sig = SEED; m_vec = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 0; m_t = 0; m_done = 0; m_pass = 0;
                m_resp = '0; m_sig = SEED; m_vec = 0;
            end else if (m_run) begin
                m_t++;
                if (m_t % HOLD == 0) begin
                    m_resp[m_t / HOLD - 1] = dut_z;
                    m_sig = crc(m_sig, dut_z);
                    if (m_t == NV * HOLD) begin
                        m_run  = 0;
                        m_done = 1;
                        m_pass = (m_sig == GOLDEN);
                    end
                end
                m_vec = m_run ? (m_t / HOLD) : 0;
            end else if (start) begin
                m_run = 1; m_t = 0; m_done = 0; m_pass = 0;
                m_resp = '0; m_sig = SEED; m_vec = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: model check every cycle, literal pins on reset and done.
    int   busy_len;
    logic prev_done;
    initial begin
        busy_len = 0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            chk("vec_out", 32'(vec_out), 32'(m_vec));
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("resp", 32'(resp), 32'(m_resp));
            chk("signature", 32'(signature), 32'(m_sig));
            chk("timeout", 32'(timed_out), 32'd0);
            if (!rst_n) begin
                chk("rst_sig", 32'(signature), 32'h0000FFFF);
                chk("rst_busy_done", 32'({busy, done, pass}), 32'd0);
                chk("rst_vec_resp", 32'({vec_out, resp}), 32'd0);
                busy_len = 0;
            end else begin
                if (busy) busy_len++;
                if (done && !prev_done) begin
                    chk("run_busy_len", 32'(busy_len), 32'd80);
                    chk("run_resp", 32'(resp), mode ? 32'h96 : 32'h00);
                    chk("run_pass", 32'(pass), 32'(mode));
                    if (mode) chk("run_sig", 32'(signature), 32'h0000E199);
                    else      chk("run_sig_ne", 32'(signature != 16'hE199), 32'd1);
                    busy_len = 0;
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) timed_out = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        total = 0;
        bad = 0;
        timed_out = 1'b0;
        mode = 1'b1;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Parity block, one clean run.
        pulse_start();
        wait_done(200);
        repeat (5) @(negedge clk);

        // Output stuck at zero.
        mode = 1'b0;
        pulse_start();
        wait_done(200);
        repeat (3) @(negedge clk);

        // Start re-pulsed mid-run is ignored.
        mode = 1'b1;
        pulse_start();
        repeat (28) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);

        // Reset while vector 4 is driven, then a clean run.
        pulse_start();
        n = 0;
        while (vec_out !== 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (vec_out !== 3'd4) timed_out = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start();
        wait_done(200);
        repeat (3) @(negedge clk);

        // Start held high: back-to-back runs.
        @(negedge clk);
        start = 1'b1;
        wait_done(200);
        @(negedge clk);
        wait_done(200);
        start = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
